// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state, config types and defaults for the serial scan controller
package seq_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int WIN_W_DEF   = 16;
  localparam int CNT_W_DEF   = 8;
  localparam int LEN_W_DEF   = $clog2(MAX_LEN_DEF + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SCAN,
    DONE
  } state_e;

  typedef struct packed {
    logic [MAX_LEN_DEF-1:0] pattern;
    logic [LEN_W_DEF-1:0]   len;
    logic                   overlap;
    logic [WIN_W_DEF-1:0]   window;
    logic [CNT_W_DEF-1:0]   target;
  } cfg_t;

  function automatic logic cfg_legal(input cfg_t cfg);
    return (cfg.len != '0) && (cfg.len <= LEN_W_DEF'(MAX_LEN_DEF)) && (cfg.window != '0);
  endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// rtl/seq_scan_ctrl_if.sv - run request, config, serial input and status bundle
interface seq_scan_ctrl_if
  import seq_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int WIN_W   = WIN_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) ();
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               start;
  logic               abort;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [WIN_W-1:0]   cfg_window;
  logic [CNT_W-1:0]   cfg_target;
  logic               in;
  logic               in_valid;
  logic               busy;
  logic               done;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               hit;
  logic               cfg_err;

  modport master (
    output start, abort, cfg_pattern, cfg_len, cfg_overlap, cfg_window, cfg_target,
           in, in_valid,
    input  busy, done, match, match_count, hit, cfg_err
  );

  modport slave (
    input  start, abort, cfg_pattern, cfg_len, cfg_overlap, cfg_window, cfg_target,
           in, in_valid,
    output busy, done, match, match_count, hit, cfg_err
  );

endinterface

// File: rtl/seq_match_core.sv
// rtl/seq_match_core.sv - shift register, fill counter and masked pattern comparator
module seq_match_core
  import seq_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift,
  input  logic               shift_bit,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               match,
  output logic               match_nxt
);

  logic [MAX_LEN-1:0] sr_q, sr_d, sr_shift, len_mask;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;
  logic               match_q, match_d, hit;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len);
    end
    sr_shift = {sr_q[MAX_LEN-2:0], shift_bit};
    fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    hit      = (fill_inc >= len) && ((sr_shift & len_mask) == (pattern & len_mask));

    sr_d    = sr_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (clr) begin
      sr_d   = '0;
      fill_d = '0;
    end else if (shift) begin
      sr_d    = sr_shift;
      match_d = hit;
      // Without overlap the matched bits must not count toward the next match.
      fill_d  = (hit && !overlap) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q    <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match     = match_q;
  assign match_nxt = match_d;

endmodule

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - run FSM, shadow config, bit/match counters and handshake outputs
module seq_scan_ctrl
  import seq_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int WIN_W   = WIN_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic            clk,
  input logic            rst,
  seq_scan_ctrl_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_e           state_q, state_d;
  cfg_t             cfg_q, cfg_d, cfg_in;
  logic [WIN_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hit_q, hit_d;
  logic             err_q, err_d;
  logic             tgt_hit;
  logic             core_clr, core_shift, core_match, core_match_nxt;

  assign core_clr   = (state_q == ARM);
  assign core_shift = (state_q == SCAN) && bus.in_valid && !bus.abort;

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .clr       (core_clr),
    .shift     (core_shift),
    .shift_bit (bus.in),
    .pattern   (cfg_q.pattern),
    .len       (cfg_q.len),
    .overlap   (cfg_q.overlap),
    .match     (core_match),
    .match_nxt (core_match_nxt)
  );

  always_comb begin
    cfg_in.pattern = bus.cfg_pattern;
    cfg_in.len     = bus.cfg_len;
    cfg_in.overlap = bus.cfg_overlap;
    cfg_in.window  = bus.cfg_window;
    cfg_in.target  = bus.cfg_target;
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    bits_d  = bits_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    err_d   = 1'b0;
    tgt_hit = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (cfg_legal(cfg_in)) begin
            state_d = ARM;
            cfg_d   = cfg_in;
            cnt_d   = '0;
            hit_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ARM: begin
        bits_d  = '0;
        state_d = bus.abort ? IDLE : SCAN;
      end
      SCAN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.in_valid) begin
          bits_d = bits_q + WIN_W'(1);
          if (core_match_nxt && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // The exit decision must see the match of the bit accepted this edge.
          tgt_hit = core_match_nxt && (cfg_q.target != '0) && (cnt_d == cfg_q.target);
          if (tgt_hit || (bits_d == cfg_q.window)) begin
            state_d = DONE;
            hit_d   = tgt_hit;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == ARM) || (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      bits_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.match       = core_match;
  assign bus.match_count = cnt_q;
  assign bus.hit         = hit_q;
  assign bus.cfg_err     = err_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - randomized bench for seq_scan_ctrl against a queue-based run model
module tb_seq_scan_ctrl;
  import seq_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int WIN_W   = 16;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_scan_ctrl_if #(.MAX_LEN(MAX_LEN), .WIN_W(WIN_W), .CNT_W(CNT_W)) bus ();

  seq_scan_ctrl #(.MAX_LEN(MAX_LEN), .WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_cnt    = 0;
  bit m_hit    = 1'b0;
  bit dq_v[$];
  bit dq_b[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_cfg();
    bus.cfg_pattern = 8'($urandom);
    bus.cfg_len     = 4'($urandom);
    bus.cfg_overlap = 1'($urandom);
    bus.cfg_window  = 16'($urandom);
    bus.cfg_target  = 8'($urandom);
  endtask

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "-") begin
        dq_v.push_back(1'b0);
        dq_b.push_back(1'($urandom));
      end else begin
        dq_v.push_back(1'b1);
        dq_b.push_back(s[i] == "1");
      end
    end
  endtask

  task automatic bad_start(input int len, input int win);
    bus.cfg_pattern = 8'($urandom);
    bus.cfg_len     = 4'(len);
    bus.cfg_window  = 16'(win);
    bus.cfg_target  = 8'($urandom);
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("err_pulse", bus.cfg_err, 1);
    check_eq("err_busy", bus.busy, 0);
    check_eq("err_count_kept", bus.match_count, m_cnt);
    check_eq("err_hit_kept", bus.hit, m_hit);
    tick();
    check_eq("err_one_cycle", bus.cfg_err, 0);
    check_eq("err_stay_idle", bus.busy, 0);
  endtask

  // kill_at: stream cycle of abort (or reset when kill_rst); -2 aborts in ARM; -1 none.
  task automatic run(input logic [7:0] pat, input int len, input bit ovl, input int win,
                     input int tgt, input int kill_at, input bit kill_rst);
    bit hist[$];
    int acc = 0;
    bit em, th, last, v, b;

    bus.cfg_pattern = pat;
    bus.cfg_len     = 4'(len);
    bus.cfg_overlap = ovl;
    bus.cfg_window  = 16'(win);
    bus.cfg_target  = 8'(tgt);
    bus.start       = 1'b1;
    bus.abort       = 1'b0;
    bus.in_valid    = 1'($urandom);
    bus.in          = 1'($urandom);
    tick();
    m_cnt = 0;
    m_hit = 1'b0;
    check_eq("arm_busy", bus.busy, 1);
    check_eq("arm_done", bus.done, 0);
    check_eq("arm_count_clr", bus.match_count, 0);
    check_eq("arm_hit_clr", bus.hit, 0);

    scramble_cfg();
    bus.in_valid = 1'b1;
    bus.in       = 1'($urandom);
    bus.start    = 1'($urandom);
    bus.abort    = (kill_at == -2);
    tick();
    if (kill_at == -2) begin
      bus.abort = 1'b0;
      bus.start = 1'b0;
      check_eq("arm_abort_busy", bus.busy, 0);
      check_eq("arm_abort_done", bus.done, 0);
      tick();
      check_eq("arm_abort_idle", bus.busy, 0);
      dq_v.delete();
      dq_b.delete();
      return;
    end

    for (int c = 0; c < 400; c++) begin
      if (dq_v.size() > 0) begin
        v = dq_v.pop_front();
        b = dq_b.pop_front();
      end else begin
        v = ($urandom_range(0, 3) != 0);
        b = 1'($urandom);
      end
      bus.in_valid = v;
      bus.in       = b;
      bus.start    = 1'($urandom);
      bus.abort    = (c == kill_at) && !kill_rst;
      scramble_cfg();

      if (c == kill_at && kill_rst) begin
        #3 rst = 1'b1;
        #1;
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_match", bus.match, 0);
        check_eq("rst_count", bus.match_count, 0);
        check_eq("rst_hit", bus.hit, 0);
        check_eq("rst_cfg_err", bus.cfg_err, 0);
        m_cnt = 0;
        m_hit = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check_eq("rst_idle", bus.busy, 0);
        dq_v.delete();
        dq_b.delete();
        return;
      end

      tick();

      if (c == kill_at) begin
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_match", bus.match, 0);
        check_eq("abort_done", bus.done, 0);
        check_eq("abort_count", bus.match_count, m_cnt);
        tick();
        check_eq("abort_idle", bus.busy, 0);
        check_eq("abort_no_done", bus.done, 0);
        check_eq("abort_count_kept", bus.match_count, m_cnt);
        dq_v.delete();
        dq_b.delete();
        return;
      end

      if (v) begin
        hist.push_back(b);
        acc++;
        em = 1'b0;
        if (hist.size() >= len) begin
          em = 1'b1;
          for (int j = 0; j < len; j++) begin
            if (hist[hist.size() - len + j] != pat[len - 1 - j]) em = 1'b0;
          end
        end
        if (em) begin
          if (m_cnt < 255) m_cnt++;
          if (!ovl) hist.delete();
        end
        th   = em && (tgt != 0) && (m_cnt == tgt);
        last = th || (acc == win);
        check_eq("match", bus.match, em);
        check_eq("count", bus.match_count, m_cnt);
        check_eq("done", bus.done, last);
        check_eq("busy", bus.busy, !last);
        if (last) begin
          m_hit = th;
          check_eq("hit", bus.hit, th);
          bus.start    = 1'b0;
          bus.abort    = 1'($urandom);
          bus.in_valid = 1'b1;
          tick();
          bus.abort = 1'b0;
          check_eq("post_done", bus.done, 0);
          check_eq("post_busy", bus.busy, 0);
          check_eq("post_match", bus.match, 0);
          check_eq("post_count", bus.match_count, m_cnt);
          check_eq("post_hit", bus.hit, m_hit);
          dq_v.delete();
          dq_b.delete();
          return;
        end
      end else begin
        check_eq("gap_match", bus.match, 0);
        check_eq("gap_done", bus.done, 0);
        check_eq("gap_busy", bus.busy, 1);
      end
    end
    check_eq("run_timeout", bus.busy, 0);
    dq_v.delete();
    dq_b.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len, win, tgt, kill;
    bit krst;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.in       = 1'b0;
    bus.in_valid = 1'b0;
    scramble_cfg();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", bus.busy, 0);
    check_eq("reset_done", bus.done, 0);
    check_eq("reset_match", bus.match, 0);
    check_eq("reset_count", bus.match_count, 0);
    check_eq("reset_hit", bus.hit, 0);
    check_eq("reset_cfg_err", bus.cfg_err, 0);
    rst = 1'b0;
    tick();

    load("1011011");
    run(8'b1011, 4, 1'b1, 7, 0, -1, 1'b0);
    check_eq("ovl_count", bus.match_count, 2);
    check_eq("ovl_hit", bus.hit, 0);

    load("1011011");
    run(8'b1011, 4, 1'b0, 7, 0, -1, 1'b0);
    check_eq("novl_count", bus.match_count, 1);

    load("111");
    run(8'b11, 2, 1'b1, 100, 2, -1, 1'b0);
    check_eq("tgt_count", bus.match_count, 2);
    check_eq("tgt_hit", bus.hit, 1);

    load("1-0-1-1");
    run(8'b1011, 4, 1'b1, 4, 0, -1, 1'b0);
    check_eq("gap_count", bus.match_count, 1);

    bad_start(0, 0);
    bad_start(4, 0);
    bad_start(9, 5);

    load("1");
    run(8'h01, 1, 1'b1, 1, 0, -1, 1'b0);
    check_eq("min_count", bus.match_count, 1);

    load("1011");
    run(8'b1011, 4, 1'b1, 100, 0, 3, 1'b0);
    check_eq("abort_final_count", bus.match_count, 0);

    load("101101");
    run(8'b1011, 4, 1'b1, 100, 0, 4, 1'b1);

    for (int i = 0; i < 300; i++) load("1");
    run(8'h01, 1, 1'b1, 300, 0, -1, 1'b0);
    check_eq("sat_count", bus.match_count, 255);

    for (int r = 0; r < 80; r++) begin
      len  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : $urandom_range(1, 3);
      win  = $urandom_range(1, 20);
      tgt  = $urandom_range(0, 3);
      kill = -1;
      krst = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        kill = $urandom_range(0, 12);
        krst = ($urandom_range(0, 3) == 0);
      end else if ($urandom_range(0, 15) == 0) begin
        kill = -2;
      end
      if ($urandom_range(0, 9) == 0) bad_start(($urandom_range(0, 1) == 0) ? 0 : 9, win);
      run(8'($urandom), len, 1'($urandom), win, tgt, kill, krst);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Run controller for serial pattern detection. Takes a run configuration: pattern, length, overlap mode, scan window and early-stop target. It arms a programmable match core, feeds it qualified serial bits, and counts matches. It reports completion with a busy/done handshake. It sits between the host/config logic and the serial input stream, as the general successor to fixed-pattern detectors.

## Interface
- MAX_LEN, 8, maximum pattern length in bits
- WIN_W, 16, width of scan-window bit counter
- CNT_W, 8, width of match counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a run; sampled only in IDLE
- abort  in  1  terminate run; returns to IDLE, no done
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first serial bit expected
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length, legal 1..MAX_LEN
- cfg_overlap  in  1  1 = overlapping matches allowed
- cfg_window  in  WIN_W  bits to scan, legal ≥1
- cfg_target  in  CNT_W  stop after this many matches; 0 = no early stop
- in  in  1  serial data bit
- in_valid  in  1  qualifies in; ignored outside SCAN
- busy  out  1  high in ARM and SCAN
- done  out  1  one-cycle pulse at run end (window exhausted or target hit)
- match  out  1  one-cycle pulse per detected match
- match_count  out  CNT_W  matches this run, saturating; holds after done until next start
- hit  out  1  high with done when the run ended on cfg_target; held until next start
- cfg_err  out  1  one-cycle pulse when start is rejected for illegal config

## Operation
- Reset values: state IDLE; busy, done, match, hit, cfg_err = 0; match_count = 0; internal shift register, fill and bit counters = 0.
- States: IDLE, ARM, SCAN, DONE.
- IDLE:
  - start with legal config (cfg_len 1..MAX_LEN, cfg_window ≠ 0) → ARM. Config is latched into shadow registers; match_count and hit are cleared.
  - start with illegal config → cfg_err pulse; stay IDLE; count and hit are not cleared.
- ARM: one cycle. Clears the shift register, fill counter and bit counter. → SCAN.
- SCAN: each cycle with in_valid=1 accepts one bit.
  - Shift register: sr ← {sr[MAX_LEN-2:0], in}.
  - fill ← min(fill+1, MAX_LEN).
  - bits ← bits+1.
- Match: after the shift, fill ≥ len and sr[len-1:0] == pattern[len-1:0]. On a match:
  - match pulses.
  - match_count increments, saturating at 2^CNT_W−1.
  - If overlap=0, fill is reset to 0, so the matched bits cannot be reused.
- Exit from SCAN:
  - bits reaches cfg_window, or (target ≠ 0 and match_count reaches target) → DONE.
  - hit=1 if the target condition caused the exit. Both conditions on the same bit: hit=1.
- DONE: one cycle. done=1, busy=0. → IDLE.
- abort in ARM or SCAN:
  - → IDLE next edge. Any bit presented in that cycle is discarded and produces no match.
  - No done pulse. match_count keeps its value.
  - abort wins over window/target completion in the same cycle.
- In IDLE and DONE, abort, in and in_valid have no effect. start during ARM/SCAN/DONE is ignored.
- Shadow config is stable for the whole run; cfg_* changes mid-run have no effect.
- Reset mid-run: immediate return to reset values; no done.

## Timing
- start at edge k → busy=1 from k (ARM). First bit can be accepted at edge k+2 (SCAN).
- Match latency: the completing bit accepted at edge k → match=1 and the updated match_count visible in the cycle after k.
- Final bit accepted at edge k:
  - DONE cycle follows k, with done=1.
  - A match on that final bit pulses in the same cycle as done.
- Minimum run, start to done: 4 cycles (window=1, in_valid held high).
- Back-to-back runs: start may be asserted in the IDLE cycle right after DONE.
- All outputs registered; no combinational input→output path.

## Structure
- Shared package seq_pkg:
  - state enum {IDLE, ARM, SCAN, DONE}.
  - Constants for the default MAX_LEN, WIN_W and CNT_W.
  - Config struct: pattern, len, overlap, window, target.
- Sub-module seq_match_core holds the shift register, fill counter and comparator.
  - Inputs: clr, shift, bit, pattern, len, overlap.
  - Output: registered match.
- seq_scan_ctrl holds the FSM, shadow config, bit counter, match counter and handshake outputs.

## Test plan
- pattern=1011, len=4, overlap=1, window=7, target=0, stream 1,0,1,1,0,1,1 with in_valid held → match after bits 4 and 7; match_count=2; done with bit 7; hit=0.
- Same stream, overlap=0 → single match after bit 4; match_count=1; done after bit 7.
- pattern=11, len=2, overlap=1, target=2, window=100, stream 1,1,1 → matches after bits 2 and 3; done after bit 3; hit=1; only 3 bits consumed.
- Gaps: window=4, pattern=1011 delivered with in_valid low between every bit → match and done only after the 4th valid bit; gap cycles change nothing.
- cfg_len=0 (then cfg_window=0) with start → cfg_err pulse, busy stays 0; a later legal start runs normally.
- Abort on the completing bit of 1011 → no match, no done, IDLE next cycle. Separately, rst asserted mid-SCAN → all outputs at reset values immediately.
